// File: rtl/buffer_sched_pkg.sv
// Shared types and helpers for the packet-buffer read scheduler.
// State encoding, default sizes and the rotate helper used by rr_pick.
package buffer_sched_pkg;

  localparam int NUM_FLOWS_DEF = 8;
  localparam int CNT_W_DEF     = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } sched_state_e;

  // Rotate the low n bits of v right by sh (n is a power of two, <= 64).
  // Bit i of the result is request (i + sh) mod n.
  function automatic logic [63:0] rot_right(
    input logic [63:0] v,
    input int unsigned sh,
    input int unsigned n
  );
    logic [63:0] r;
    logic [5:0]  j;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      j = 6'((i + sh) & (n - 1));
      if (i < n) r[i] = v[j];
    end
    return r;
  endfunction

endpackage

// File: rtl/flow_rr_scheduler_rr_pick.sv
// Combinational round-robin selector.
// Returns the first set request at or above ptr, wrapping modulo N.
module rr_pick
  import buffer_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [63:0]  req_ext;
  logic [63:0]  rot;
  logic [W-1:0] off;

  // Rotate so ptr lands on bit 0, then take the lowest set bit.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    rot            = rot_right(req_ext, 32'(ptr), N);
    found          = |rot[N-1:0];
    off            = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    idx = ptr + off;
  end

endmodule

// File: rtl/flow_rr_scheduler.sv
// Read-side packet scheduler: per-flow pending counters and a
// round-robin grant FSM that holds one grant until the packet ends.
module flow_rr_scheduler
  import buffer_sched_pkg::*;
#(
  parameter int NUM_FLOWS = NUM_FLOWS_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FLOW_W    = $clog2(NUM_FLOWS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enq_valid,
  input  logic [FLOW_W-1:0]    enq_flow,
  input  logic [NUM_FLOWS-1:0] flow_en,
  output logic                 sel_valid,
  output logic [FLOW_W-1:0]    sel_flow,
  input  logic                 sel_ready,
  input  logic                 rd_done,
  output logic                 pend_any,
  output logic                 err_ovf,
  output logic                 err_proto
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_e        state_q, state_d;
  logic [FLOW_W-1:0]   ptr_q, ptr_d;
  logic [FLOW_W-1:0]   sel_flow_q, sel_flow_d;
  logic                sel_valid_q, sel_valid_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_proto_q, err_proto_d;
  logic [CNT_W-1:0]    cnt_q [NUM_FLOWS];
  logic [CNT_W-1:0]    cnt_d [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] elig, inc_v, dec_v;
  logic                hs, pick_found, pend;
  logic [FLOW_W-1:0]   pick_idx;

  assign hs = sel_valid_q & sel_ready;

  // Eligibility and pending summary from the registered counters.
  always_comb begin
    pend = 1'b0;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      elig[f] = (cnt_q[f] != '0) & flow_en[f];
      pend    = pend | (cnt_q[f] != '0);
    end
  end

  rr_pick #(
    .N (NUM_FLOWS),
    .W (FLOW_W)
  ) u_pick (
    .req   (elig),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Counter updates; same-flow enqueue and handshake cancel out.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (enq_valid) inc_v[enq_flow] = 1'b1;
    if (hs) dec_v[sel_flow_q] = 1'b1;
    err_ovf_d = err_ovf_q |
      (enq_valid & (cnt_q[enq_flow] == CNT_MAX));
    for (int f = 0; f < NUM_FLOWS; f++) begin
      cnt_d[f] = cnt_q[f];
      if (inc_v[f] & ~dec_v[f] & (cnt_q[f] != CNT_MAX))
        cnt_d[f] = cnt_q[f] + CNT_W'(1);
      else if (dec_v[f] & ~inc_v[f])
        cnt_d[f] = cnt_q[f] - CNT_W'(1);
    end
  end

  // Grant FSM: pick in IDLE, hold offer in GRANT, wait end in BUSY.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_flow_d  = sel_flow_q;
    sel_valid_d = sel_valid_q;
    err_proto_d = err_proto_q |
      (rd_done & (state_q != ST_BUSY));
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_GRANT;
          sel_flow_d  = pick_idx;
          sel_valid_d = 1'b1;
        end
      end
      ST_GRANT: begin
        if (hs) begin
          state_d     = ST_BUSY;
          sel_valid_d = 1'b0;
          ptr_d       = sel_flow_q + FLOW_W'(1);
        end
      end
      ST_BUSY: begin
        if (rd_done) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        sel_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sel_flow_q  <= '0;
      sel_valid_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
      for (int f = 0; f < NUM_FLOWS; f++) cnt_q[f] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_flow_q  <= sel_flow_d;
      sel_valid_q <= sel_valid_d;
      err_ovf_q   <= err_ovf_d;
      err_proto_q <= err_proto_d;
      for (int f = 0; f < NUM_FLOWS; f++) cnt_q[f] <= cnt_d[f];
    end
  end

  assign sel_valid = sel_valid_q;
  assign sel_flow  = sel_flow_q;
  assign pend_any  = pend;
  assign err_ovf   = err_ovf_q;
  assign err_proto = err_proto_q;

endmodule
